// File: rtl/nes_pad_pkg.sv
// Shared constants for the multi-port game-pad model: button bit positions
// within a pad word and the standard shift lengths for NES and SNES pads.
package nes_pad_pkg;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // Extra SNES buttons, shifted out after the NES-compatible eight
    localparam int BTN_SA     = 8;
    localparam int BTN_SX     = 9;
    localparam int BTN_SL     = 10;
    localparam int BTN_SR     = 11;

    localparam int NES_BITS   = 8;
    localparam int SNES_BITS  = 16;

endpackage

// File: rtl/nes_pad_shifter.sv
// One 4021-style parallel-in/serial-out pad: level-sensitive load, rd edge
// shifting with a constant fill, and a saturating read counter with done flag.
module nes_pad_shifter
    import nes_pad_pkg::*;
#(
    parameter int   BITS      = NES_BITS,
    parameter logic POST_READ = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            strobe,
    input  logic            rd,
    input  logic [BITS-1:0] eff,
    output logic            data,
    output logic            done
);

    localparam int              CNT_W   = $clog2(BITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BITS);

    logic [BITS-1:0]  sr;
    logic [CNT_W-1:0] cnt;
    logic             rd_r;
    logic             rd_edge;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= CNT_MAX) ? CNT_MAX : c + 1'b1;
    endfunction

    assign rd_edge = rd & ~rd_r;
    assign data    = ~sr[0];

    // rd history always follows rd, so a read held across strobe falling is not a new edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr   <= '0;
            cnt  <= '0;
            done <= 1'b0;
            rd_r <= 1'b0;
        end else begin
            rd_r <= rd;
            if (strobe) begin
                sr   <= eff;
                cnt  <= '0;
                done <= 1'b0;
            end else if (rd_edge) begin
                sr   <= {~POST_READ, sr[BITS-1:1]};
                cnt  <= sat_inc(cnt);
                done <= (sat_inc(cnt) == CNT_MAX);
            end
        end
    end

endmodule

// File: rtl/nes_pad_multi.sv
// Multi-port game-pad model: NUM_PADS independent shifters behind a shared
// strobe, with a free-running turbo timer that masks turbo-enabled buttons.
module nes_pad_multi
    import nes_pad_pkg::*;
#(
    parameter int          NUM_PADS     = 2,
    parameter int          BITS         = NES_BITS,
    parameter logic        POST_READ    = 1'b1,
    parameter int unsigned TURBO_PERIOD = 800000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     strobe,
    input  logic [NUM_PADS-1:0]      rd,
    input  logic [NUM_PADS*BITS-1:0] btns,
    input  logic [NUM_PADS*BITS-1:0] turbo_en,
    output logic [NUM_PADS-1:0]      data,
    output logic [NUM_PADS-1:0]      done,
    output logic                     turbo_phase
);

    localparam int            TW         = $clog2(TURBO_PERIOD);
    localparam logic [TW-1:0] TURBO_LAST = TW'(TURBO_PERIOD - 1);

    logic [TW-1:0]            turbo_cnt;
    logic [NUM_PADS*BITS-1:0] eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            turbo_cnt   <= '0;
            turbo_phase <= 1'b0;
        end else if (turbo_cnt == TURBO_LAST) begin
            turbo_cnt   <= '0;
            turbo_phase <= ~turbo_phase;
        end else begin
            turbo_cnt   <= turbo_cnt + 1'b1;
        end
    end

    // Turbo buttons read released during phase 0 and pass through during phase 1
    assign eff = btns & ~(turbo_en & {(NUM_PADS*BITS){~turbo_phase}});

    for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
        nes_pad_shifter #(
            .BITS      (BITS),
            .POST_READ (POST_READ)
        ) u_pad (
            .clk    (clk),
            .rst_n  (rst_n),
            .strobe (strobe),
            .rd     (rd[i]),
            .eff    (eff[i*BITS +: BITS]),
            .data   (data[i]),
            .done   (done[i])
        );
    end

endmodule

// File: tb/tb_nes_pad_multi.sv
// Bench for nes_pad_multi: a two-pad NES instance and a one-pad SNES instance
// with a short turbo period, checked against a read-index reference model.
module tb_nes_pad_multi;

    localparam int          N0 = 2;
    localparam int          B0 = 8;
    localparam int unsigned P0 = 800000;
    localparam int          N1 = 1;
    localparam int          B1 = 16;
    localparam int unsigned P1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic              strobe0;
    logic [N0-1:0]     rd0;
    logic [N0*B0-1:0]  btns0, ten0;
    logic [N0-1:0]     data0, done0;
    logic              tph0;

    logic              strobe1;
    logic [N1-1:0]     rd1;
    logic [N1*B1-1:0]  btns1, ten1;
    logic [N1-1:0]     data1, done1;
    logic              tph1;

    int errors = 0;
    int checks = 0;

    nes_pad_multi #(.NUM_PADS(N0), .BITS(B0), .POST_READ(1'b1), .TURBO_PERIOD(P0)) u_nes (
        .clk(clk), .rst_n(rst_n), .strobe(strobe0), .rd(rd0), .btns(btns0),
        .turbo_en(ten0), .data(data0), .done(done0), .turbo_phase(tph0)
    );

    nes_pad_multi #(.NUM_PADS(N1), .BITS(B1), .POST_READ(1'b1), .TURBO_PERIOD(P1)) u_snes (
        .clk(clk), .rst_n(rst_n), .strobe(strobe1), .rd(rd1), .btns(btns1),
        .turbo_en(ten1), .data(data1), .done(done1), .turbo_phase(tph1)
    );

    // Reference model: each pad holds the image latched at the last load and
    // how many bits have been read since; turbo phase is clock count / period.
    logic [B0-1:0] img0 [N0];
    int            idx0 [N0];
    logic [N0-1:0] rdp0;
    int unsigned   ecnt0;
    logic [B1-1:0] img1 [N1];
    int            idx1 [N1];
    logic [N1-1:0] rdp1;
    int unsigned   ecnt1;

    function automatic logic [B0-1:0] eff0(int p, int unsigned e);
        return btns0[p*B0 +: B0] & ~((((e / P0) % 2) == 1) ? '0 : ten0[p*B0 +: B0]);
    endfunction

    function automatic logic [B1-1:0] eff1(int p, int unsigned e);
        return btns1[p*B1 +: B1] & ~((((e / P1) % 2) == 1) ? '0 : ten1[p*B1 +: B1]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < N0; p++) begin
                img0[p] <= '0;
                idx0[p] <= 0;
            end
            for (int p = 0; p < N1; p++) begin
                img1[p] <= '0;
                idx1[p] <= 0;
            end
            rdp0  <= '0;
            rdp1  <= '0;
            ecnt0 <= 0;
            ecnt1 <= 0;
        end else begin
            for (int p = 0; p < N0; p++) begin
                if (strobe0) begin
                    img0[p] <= eff0(p, ecnt0);
                    idx0[p] <= 0;
                end else if (rd0[p] && !rdp0[p]) begin
                    idx0[p] <= (idx0[p] < B0) ? idx0[p] + 1 : B0;
                end
            end
            for (int p = 0; p < N1; p++) begin
                if (strobe1) begin
                    img1[p] <= eff1(p, ecnt1);
                    idx1[p] <= 0;
                end else if (rd1[p] && !rdp1[p]) begin
                    idx1[p] <= (idx1[p] < B1) ? idx1[p] + 1 : B1;
                end
            end
            rdp0  <= rd0;
            rdp1  <= rd1;
            ecnt0 <= ecnt0 + 1;
            ecnt1 <= ecnt1 + 1;
        end
    end

    function automatic logic exp_data0(int p);
        return (idx0[p] < B0) ? ~img0[p][idx0[p]] : 1'b1;
    endfunction

    function automatic logic exp_data1(int p);
        return (idx1[p] < B1) ? ~img1[p][idx1[p]] : 1'b1;
    endfunction

    function automatic logic exp_phase0();
        return ((ecnt0 / P0) % 2) == 1;
    endfunction

    function automatic logic exp_phase1();
        return ((ecnt1 / P1) % 2) == 1;
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (data0 !== 2'b11 || done0 !== 2'b00 || tph0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_nes: data=%b done=%b phase=%b, want data=11 done=00 phase=0", data0, done0, tph0);
        end
        checks++;
        if (data1 !== 1'b1 || done1 !== 1'b0 || tph1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_snes: data=%b done=%b phase=%b, want 1 0 0", data1, done1, tph1);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (data0 !== 2'b11 || done0 !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: data=%b done=%b, want data=11 done=00", data0, done0);
        end
    endtask

    task automatic test_nes_read();
        logic [7:0] seq;
        seq = 8'b0111_1110;
        btns0 = {8'h00, 8'h81};
        strobe0 = 1'b1;
        @(negedge clk);
        strobe0 = 1'b0;
        checks++;
        if (data0[0] !== seq[0] || done0[0] !== 1'b0) begin
            errors++;
            $display("FAIL nes_load: data=%b done=%b, want data=%b done=0", data0[0], done0[0], seq[0]);
        end
        for (int k = 1; k <= 12; k++) begin
            rd0[0] = 1'b1;
            @(negedge clk);
            checks++;
            if (data0[0] !== ((k < 8) ? seq[k] : 1'b1) || done0[0] !== (k >= 8)) begin
                errors++;
                $display("FAIL nes_read%0d: data=%b done=%b, want data=%b done=%b",
                         k, data0[0], done0[0], (k < 8) ? seq[k] : 1'b1, k >= 8);
            end
            rd0[0] = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_level_strobe();
        strobe0 = 1'b1;
        btns0[7:0] = 8'h00;
        @(negedge clk);
        checks++;
        if (data0[0] !== 1'b1) begin
            errors++;
            $display("FAIL level_released: data=%b, want 1", data0[0]);
        end
        btns0[7:0] = 8'h01;
        @(negedge clk);
        checks++;
        if (data0[0] !== 1'b0) begin
            errors++;
            $display("FAIL level_pressed: data=%b, want 0", data0[0]);
        end
        for (int k = 0; k < 4; k++) begin
            rd0[0] = ~rd0[0];
            @(negedge clk);
            checks++;
            if (data0[0] !== 1'b0 || done0[0] !== 1'b0) begin
                errors++;
                $display("FAIL level_rd_ignored%0d: data=%b done=%b, want 0 0", k, data0[0], done0[0]);
            end
        end
        strobe0 = 1'b0;
        @(negedge clk);
        rd0[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (data0[0] !== 1'b1) begin
            errors++;
            $display("FAIL level_b_bit: data=%b, want 1", data0[0]);
        end
        rd0[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_priority();
        btns0[7:0] = 8'h01;
        strobe0 = 1'b1;
        rd0[0] = 1'b1;
        @(negedge clk);
        strobe0 = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (data0[0] !== 1'b0) begin
                errors++;
                $display("FAIL prio_hold_rd: data=%b, want 0 (A, no shift)", data0[0]);
            end
        end
        rd0[0] = 1'b0;
        @(negedge clk);
        rd0[0] = 1'b1;
        @(negedge clk);
        rd0[0] = 1'b0;
        @(negedge clk);
        strobe0 = 1'b1;
        rd0[0] = 1'b1;
        @(negedge clk);
        strobe0 = 1'b0;
        @(negedge clk);
        checks++;
        if (data0[0] !== 1'b0 || done0[0] !== 1'b0) begin
            errors++;
            $display("FAIL prio_load_wins: data=%b done=%b, want 0 0", data0[0], done0[0]);
        end
        rd0[0] = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            rd0[0] = 1'b1;
            @(negedge clk);
            checks++;
            if (done0[0] !== (k == 8)) begin
                errors++;
                $display("FAIL prio_cnt_read%0d: done=%b, want %b", k, done0[0], k == 8);
            end
            rd0[0] = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_two_pads();
        btns0 = {8'h02, 8'h01};
        rd0 = '0;
        strobe0 = 1'b1;
        @(negedge clk);
        strobe0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rd0[1] = 1'b1;
            @(negedge clk);
            rd0[1] = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (data0 !== 2'b10 || done0 !== 2'b00) begin
            errors++;
            $display("FAIL two_pads: data=%b done=%b, want data=10 done=00", data0, done0);
        end
    endtask

    task automatic test_reset_mid();
        btns0 = {8'h3C, 8'h81};
        strobe0 = 1'b1;
        @(negedge clk);
        strobe0 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rd0 = 2'b11;
            @(negedge clk);
            rd0 = 2'b00;
            @(negedge clk);
        end
        checks++;
        if (done0 !== 2'b11) begin
            errors++;
            $display("FAIL mid_pre_done: done=%b, want 11", done0);
        end
        btns0 = {8'h00, 8'h01};
        strobe0 = 1'b1;
        @(negedge clk);
        strobe0 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (data0 !== 2'b11 || done0 !== 2'b00 || tph1 !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_reset: data=%b done=%b phase1=%b, want 11 00 0", data0, done0, tph1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (data0 !== 2'b11 || done0 !== 2'b00) begin
            errors++;
            $display("FAIL mid_after_release: data=%b done=%b, want 11 00", data0, done0);
        end
    endtask

    task automatic test_turbo_snes();
        logic [15:0] pat;
        bit saw0, saw1, got_phase1;
        saw0 = 0;
        saw1 = 0;
        got_phase1 = 0;
        pat = 16'hA5A1;
        btns1 = pat;
        ten1 = 16'h0001;
        strobe1 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (tph1 !== exp_phase1() || data1[0] !== exp_data1(0)) begin
                errors++;
                $display("FAIL turbo_load%0d: phase=%b data=%b, want phase=%b data=%b",
                         k, tph1, data1[0], exp_phase1(), exp_data1(0));
            end
            if (data1[0] === 1'b0) saw0 = 1;
            if (data1[0] === 1'b1) saw1 = 1;
        end
        checks++;
        if (!(saw0 && saw1)) begin
            errors++;
            $display("FAIL turbo_both_phases: saw0=%0d saw1=%0d, want 1 1", saw0, saw1);
        end
        for (int k = 0; k < 8 && !got_phase1; k++) begin
            @(negedge clk);
            if (exp_phase1()) got_phase1 = 1;
        end
        @(negedge clk);
        strobe1 = 1'b0;
        checks++;
        if (!got_phase1 || data1[0] !== 1'b0) begin
            errors++;
            $display("FAIL turbo_phase1_load: found=%0d data=%b, want 1 0", got_phase1, data1[0]);
        end
        for (int k = 1; k <= 17; k++) begin
            rd1[0] = 1'b1;
            @(negedge clk);
            checks++;
            if (data1[0] !== ((k < 16) ? ~pat[k] : 1'b1) || done1[0] !== (k >= 16)) begin
                errors++;
                $display("FAIL snes_read%0d: data=%b done=%b, want data=%b done=%b",
                         k, data1[0], done1[0], (k < 16) ? ~pat[k] : 1'b1, k >= 16);
            end
            rd1[0] = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            strobe0 = ($urandom % 8) == 0;
            strobe1 = ($urandom % 8) == 0;
            rd0 = N0'($urandom);
            rd1 = N1'($urandom);
            if ($urandom % 4 == 0) btns0 = (N0*B0)'($urandom);
            if ($urandom % 4 == 0) btns1 = (N1*B1)'($urandom);
            if ($urandom % 16 == 0) ten0 = (N0*B0)'($urandom);
            if ($urandom % 16 == 0) ten1 = (N1*B1)'($urandom);
            @(negedge clk);
            for (int p = 0; p < N0; p++) begin
                checks++;
                if (data0[p] !== exp_data0(p) || done0[p] !== (idx0[p] >= B0)) begin
                    errors++;
                    $display("FAIL rand_nes%0d c%0d: data=%b done=%b, want data=%b done=%b",
                             p, c, data0[p], done0[p], exp_data0(p), idx0[p] >= B0);
                end
            end
            checks++;
            if (data1[0] !== exp_data1(0) || done1[0] !== (idx1[0] >= B1) ||
                tph1 !== exp_phase1() || tph0 !== exp_phase0()) begin
                errors++;
                $display("FAIL rand_snes c%0d: data=%b done=%b ph1=%b ph0=%b, want %b %b %b %b",
                         c, data1[0], done1[0], tph1, tph0, exp_data1(0), idx1[0] >= B1,
                         exp_phase1(), exp_phase0());
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        strobe0 = 1'b0;
        rd0     = '0;
        btns0   = '0;
        ten0    = '0;
        strobe1 = 1'b0;
        rd1     = '0;
        btns1   = '0;
        ten1    = '0;
        test_reset();
        test_nes_read();
        test_level_strobe();
        test_priority();
        test_two_pads();
        test_reset_mid();
        test_turbo_snes();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
